// File: rtl/inst_sram_resp.sv
// Instruction-port SRAM adapter: turns a single-cycle SRAM-style fetch into a stalled
// backing-memory read with timeout. Optional one-entry fetch buffer: INST_SRAM_RESP_BUF_EN.
module inst_sram_resp #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        stallreq,
  output logic        inst_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       paddr;
  logic [31:0]       paddr_reg;
  logic [31:0]       rdata_reg;
  logic [CNT_W-1:0]  cnt;
  logic              err_reg;
  logic              fetch_req;
  logic              wen_fault;
  logic              buf_hit;
  logic              timeout;
  logic              stall_c;
  logic              unused_inputs;

`ifdef INST_SRAM_RESP_BUF_EN
  logic              buf_valid;
  logic [31:0]       buf_addr;
  logic [31:0]       buf_data;

  assign buf_hit = buf_valid && (buf_addr == paddr);
`else
  assign buf_hit = 1'b0;
`endif

  assign paddr           = {3'b000, inst_sram_addr[28:0]};
  assign fetch_req       = inst_sram_en && (inst_sram_wen == 4'b0000);
  assign wen_fault       = inst_sram_en && (inst_sram_wen != 4'b0000);
  assign timeout         = (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign inst_sram_rdata = rdata_reg;
  assign inst_err        = err_reg;
  assign unused_inputs   = ^{inst_sram_wdata, inst_sram_addr[31:29]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ack wins over timeout when both land in the same WAIT cycle.
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    case (state)
      IDLE: begin
        if (fetch_req && !buf_hit) begin
          state_nxt = WAIT;
          stall_c   = 1'b1;
        end
      end
      WAIT: begin
        mem_req  = 1'b1;
        mem_addr = paddr_reg;
        if (mem_ack || timeout) state_nxt = IDLE;
        else                    stall_c   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    stallreq = rst ? 1'b0 : stall_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_reg <= 32'h0;
      rdata_reg <= 32'h0;
      cnt       <= '0;
      err_reg   <= 1'b0;
`ifdef INST_SRAM_RESP_BUF_EN
      buf_valid <= 1'b0;
`endif
    end else begin
      err_reg <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (wen_fault) begin
            rdata_reg <= 32'h0;
            err_reg   <= 1'b1;
          end else if (fetch_req) begin
`ifdef INST_SRAM_RESP_BUF_EN
            if (buf_hit) rdata_reg <= buf_data;
            else         paddr_reg <= paddr;
`else
            paddr_reg <= paddr;
`endif
          end
        end
        WAIT: begin
          if (mem_ack) begin
            rdata_reg <= mem_rdata;
`ifdef INST_SRAM_RESP_BUF_EN
            buf_valid <= 1'b1;
            buf_addr  <= paddr_reg;
            buf_data  <= mem_rdata;
`endif
          end else if (timeout) begin
            rdata_reg <= 32'h0;
            err_reg   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed, table-driven bench for inst_sram_resp (TIMEOUT_CYCLES=4); buffer checks
// follow INST_SRAM_RESP_BUF_EN.
module tb_inst_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        stallreq;
  logic        inst_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] mrd;
    logic        e_stall;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  inst_sram_resp #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .stallreq(stallreq), .inst_err(inst_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic ack, input logic [31:0] mrd,
                              input logic es, input logic emr, input logic [31:0] ema,
                              input logic [31:0] erd, input logic eer);
    vec_t v;
    v.rst = r; v.en = en; v.wen = wen; v.addr = addr; v.ack = ack; v.mrd = mrd;
    v.e_stall = es; v.e_mreq = emr; v.e_maddr = ema; v.e_rdata = erd; v.e_err = eer;
    return v;
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst             = v.rst;
    inst_sram_en    = v.en;
    inst_sram_wen   = v.wen;
    inst_sram_addr  = v.addr;
    inst_sram_wdata = 32'hA5A5A5A5;
    mem_ack         = v.ack;
    mem_rdata       = v.mrd;
    #1;
  endtask

  task automatic checkField(input string nm, input int idx, input logic [31:0] act,
                            input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkField("stallreq", idx, {31'b0, stallreq}, {31'b0, v.e_stall});
    checkField("mem_req", idx, {31'b0, mem_req}, {31'b0, v.e_mreq});
    checkField("mem_addr", idx, mem_addr, v.e_maddr);
    checkField("rdata", idx, inst_sram_rdata, v.e_rdata);
    checkField("inst_err", idx, {31'b0, inst_err}, {31'b0, v.e_err});
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v);
    checkOutput(v, idx);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t idle_v;
    int   req_cycles;
    int   stall_cycles;
    int   err_pulses;

    idle_v = mk(0,0,4'h0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0);
    applyStimulus(mk(1,0,4'h0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0));
    applyStimulus(mk(1,0,4'h0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0));

    // Reset state, stallreq forced low while rst is high.
    vecs.push_back(mk(1,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,1,4'h0,32'hBFC00000, 0,32'h0,        0,0,32'h0,        32'h0,        0));
    // Fetch with ack in the third WAIT cycle: stall high 3 cycles.
    vecs.push_back(mk(0,1,4'h0,32'hBFC00000, 0,32'h0,        1,0,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00000, 0,32'h0,        1,1,32'h1FC00000, 32'h0,        0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00000, 0,32'h0,        1,1,32'h1FC00000, 32'h0,        0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00000, 1,32'h3C08BFC0, 0,1,32'h1FC00000, 32'h0,        0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h3C08BFC0, 0));
    // Stray ack in IDLE is ignored; rdata holds with en low.
    vecs.push_back(mk(0,0,4'h0,32'h0,        1,32'hDEADBEEF, 0,0,32'h0,        32'h3C08BFC0, 0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h3C08BFC0, 0));
    // Ack in the first WAIT cycle.
    vecs.push_back(mk(0,1,4'h0,32'hBFC00010, 0,32'h0,        1,0,32'h0,        32'h3C08BFC0, 0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00010, 1,32'h11112222, 0,1,32'h1FC00010, 32'h3C08BFC0, 0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h11112222, 0));
    // Write enables on the instruction port.
    vecs.push_back(mk(0,1,4'hF,32'h80000000, 0,32'h0,        0,0,32'h0,        32'h11112222, 0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h0,        1));
    vecs.push_back(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h0,        0));
    // Reset in the second WAIT cycle, then a late ack.
    vecs.push_back(mk(0,1,4'h0,32'hBFC00020, 0,32'h0,        1,0,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00020, 0,32'h0,        1,1,32'h1FC00020, 32'h0,        0));
    vecs.push_back(mk(1,1,4'h0,32'hBFC00020, 0,32'h0,        0,1,32'h1FC00020, 32'h0,        0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        1,32'hCAFEF00D, 0,0,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h0,        0));
    // Prime rdata with a nonzero word, then accept a fetch that never gets an ack.
    vecs.push_back(mk(0,1,4'h0,32'hBFC00030, 0,32'h0,        1,0,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00030, 1,32'h55AA55AA, 0,1,32'h1FC00030, 32'h0,        0));
    vecs.push_back(mk(0,1,4'h0,32'hBFC00040, 0,32'h0,        1,0,32'h0,        32'h55AA55AA, 0));

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], i);

    // Timeout: count WAIT cycles until mem_req drops, bounded.
    req_cycles   = 0;
    stall_cycles = 0;
    err_pulses   = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(idle_v);
      if (inst_err) err_pulses++;
      if (!mem_req) break;
      req_cycles++;
      if (stallreq) stall_cycles++;
    end
    checkField("timeout_req_cycles", 100, req_cycles, 5);
    checkField("timeout_stall_cycles", 101, stall_cycles, 4);
    checkField("timeout_err", 102, {31'b0, inst_err}, 32'd1);
    checkField("timeout_rdata", 103, inst_sram_rdata, 32'h0);
    checkField("timeout_stall_after", 104, {31'b0, stallreq}, 32'd0);
    applyStimulus(idle_v);
    if (inst_err) err_pulses++;
    checkField("timeout_err_pulses", 105, err_pulses, 1);
    checkField("timeout_mem_req_after", 106, {31'b0, mem_req}, 32'd0);

    // Back-to-back fetches of the same address.
    runVec(mk(0,1,4'h0,32'hBFC00004, 0,32'h0,        1,0,32'h0,        32'h0,        0), 200);
    runVec(mk(0,1,4'h0,32'hBFC00004, 1,32'h24080001, 0,1,32'h1FC00004, 32'h0,        0), 201);
`ifdef INST_SRAM_RESP_BUF_EN
    runVec(mk(0,1,4'h0,32'hBFC00004, 0,32'h0,        0,0,32'h0,        32'h24080001, 0), 202);
    runVec(mk(0,1,4'hF,32'h80000000, 0,32'h0,        0,0,32'h0,        32'h24080001, 0), 203);
    runVec(mk(0,1,4'h0,32'hBFC00004, 0,32'h0,        0,0,32'h0,        32'h0,        1), 204);
    runVec(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h24080001, 0), 205);
`else
    runVec(mk(0,1,4'h0,32'hBFC00004, 0,32'h0,        1,0,32'h0,        32'h24080001, 0), 202);
    runVec(mk(0,1,4'h0,32'hBFC00004, 1,32'h24080001, 0,1,32'h1FC00004, 32'h24080001, 0), 203);
    runVec(mk(0,1,4'hF,32'h80000000, 0,32'h0,        0,0,32'h0,        32'h24080001, 0), 204);
    runVec(mk(0,0,4'h0,32'h0,        0,32'h0,        0,0,32'h0,        32'h0,        1), 205);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
